// File: rtl/sctag_cpx_pkg.sv
// Shared types for the sctag->CPX return-path output queue: packet payload,
// FSM state encoding and a CPU-id decode helper.
package sctag_cpx_pkg;

  localparam int unsigned CPX_PKT_W = 145;
  localparam int unsigned NCPU      = 8;
  localparam int unsigned CPU_W     = $clog2(NCPU);

  typedef struct packed {
    logic [CPX_PKT_W-1:0] data;
    logic [CPU_W-1:0]     cpu;
    logic                 atom;
  } cpx_pkt_t;

  // State names what is on the request bus in the current cycle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ATOM1 = 2'd2,
    ST_ATOM2 = 2'd3
  } cpx_state_e;

  function automatic logic [NCPU-1:0] cpu_onehot(input logic [CPU_W-1:0] cpu);
    cpu_onehot = NCPU'(1) << cpu;
  endfunction

endpackage

// File: rtl/sctag_cpx_credit.sv
// Per-CPU CPX credit counters; decremented on issue, incremented on grant,
// exported as "at least one" / "at least two" eligibility vectors.
module sctag_cpx_credit
  import sctag_cpx_pkg::*;
#(
  parameter int unsigned CREDITS = 2
) (
  input  logic            rclk,
  input  logic            arst,
  input  logic [NCPU-1:0] issue_i,
  input  logic [NCPU-1:0] grant_i,
  output logic [NCPU-1:0] ge1_o,
  output logic [NCPU-1:0] ge2_o
);

  localparam int unsigned CRED_W = $clog2(CREDITS + 1);

  logic [CRED_W-1:0] credit_q [NCPU];
  logic [CRED_W-1:0] credit_d [NCPU];

  always_comb begin
    for (int i = 0; i < NCPU; i++) begin
      credit_d[i] = credit_q[i] - CRED_W'(issue_i[i]) + CRED_W'(grant_i[i]);
      ge1_o[i]    = (credit_q[i] != '0);
      ge2_o[i]    = (32'(credit_q[i]) >= 32'd2);
    end
  end

  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < NCPU; i++) credit_q[i] <= CRED_W'(CREDITS);
    end else begin
      for (int i = 0; i < NCPU; i++) credit_q[i] <= credit_d[i];
    end
  end

  // Grant beyond the pool size or issue without credit indicates a protocol bug.
  always_ff @(posedge rclk) begin
    if (!arst) begin
      for (int i = 0; i < NCPU; i++) begin
        assert (!(grant_i[i] && !issue_i[i] && credit_q[i] == CRED_W'(CREDITS)));
        assert (!(issue_i[i] && credit_q[i] == '0));
      end
    end
  end

endmodule

// File: rtl/sctag_cpx_outq.sv
// sctag->CPX output queue: packet FIFO, issue FSM and registered CPX outputs.
// Optional stall counter enabled by defining SCTAG_CPX_STALL_CNT_EN.
module sctag_cpx_outq
  import sctag_cpx_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CREDITS = 2
) (
  input  logic                 rclk,
  input  logic                 arst,
  input  logic                 in_vld,
  input  logic [CPU_W-1:0]     in_cpu,
  input  logic                 in_atom,
  input  logic [CPX_PKT_W-1:0] in_data,
  output logic                 in_stall,
  output logic [NCPU-1:0]      sctag_cpx_req_cq,
  output logic                 sctag_cpx_atom_cq,
  output logic [CPX_PKT_W-1:0] sctag_cpx_data_ca,
  input  logic [NCPU-1:0]      cpx_sctag_grant_cx
`ifdef SCTAG_CPX_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  cpx_pkt_t             fifo_q [DEPTH];
  cpx_pkt_t             head_c;
  cpx_pkt_t             in_pkt_c;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]     occ_q, occ_d;
  cpx_state_e           state_q, state_d;
  logic [NCPU-1:0]      req_d, ge1, ge2;
  logic                 atom_d, push_c, pop_c, full_c, head_vld_c, pair_rdy_c, blocked_c;
  logic [CPX_PKT_W-1:0] stage_q;
  logic                 stage_vld_q;

  assign in_pkt_c   = '{data: in_data, cpu: in_cpu, atom: in_atom};
  assign head_c     = fifo_q[rd_ptr_q];
  assign full_c     = (occ_q == OCC_W'(DEPTH));
  assign head_vld_c = (occ_q != '0);
  assign pair_rdy_c = (occ_q >= OCC_W'(2));
  assign push_c     = in_vld & ~full_c;
  assign occ_d      = occ_q + OCC_W'(push_c) - OCC_W'(pop_c);

  sctag_cpx_credit #(.CREDITS(CREDITS)) u_credit (
    .rclk    (rclk),
    .arst    (arst),
    .issue_i (req_d),
    .grant_i (cpx_sctag_grant_cx),
    .ge1_o   (ge1),
    .ge2_o   (ge2)
  );

  // Issue decision; the second half of a pair is forced out right after the first.
  always_comb begin
    state_d   = ST_IDLE;
    req_d     = '0;
    atom_d    = 1'b0;
    pop_c     = 1'b0;
    blocked_c = 1'b0;
    if (state_q == ST_ATOM1) begin
      state_d = ST_ATOM2;
      pop_c   = 1'b1;
      req_d   = cpu_onehot(head_c.cpu);
    end else if (head_vld_c) begin
      if (!head_c.atom) begin
        if (ge1[head_c.cpu]) begin
          state_d = ST_ISSUE;
          pop_c   = 1'b1;
          req_d   = cpu_onehot(head_c.cpu);
        end else begin
          blocked_c = 1'b1;
        end
      end else if (!ge2[head_c.cpu]) begin
        blocked_c = 1'b1;
      end else if (pair_rdy_c) begin
        state_d = ST_ATOM1;
        pop_c   = 1'b1;
        atom_d  = 1'b1;
        req_d   = cpu_onehot(head_c.cpu);
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (push_c) fifo_q[wr_ptr_q] <= in_pkt_c;
  end

  // Data trails its request by one cycle through the staging register.
  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      occ_q             <= '0;
      state_q           <= ST_IDLE;
      in_stall          <= 1'b0;
      sctag_cpx_req_cq  <= '0;
      sctag_cpx_atom_cq <= 1'b0;
      sctag_cpx_data_ca <= '0;
      stage_q           <= '0;
      stage_vld_q       <= 1'b0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        stage_q  <= head_c.data;
      end
      occ_q             <= occ_d;
      state_q           <= state_d;
      in_stall          <= (occ_d >= OCC_W'(DEPTH - 1));
      sctag_cpx_req_cq  <= req_d;
      sctag_cpx_atom_cq <= atom_d;
      stage_vld_q       <= pop_c;
      if (stage_vld_q) sctag_cpx_data_ca <= stage_q;
    end
  end

  always_ff @(posedge rclk) begin
    if (!arst) assert (!(in_vld && full_c));
  end

`ifdef SCTAG_CPX_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      stall_cnt_q <= '0;
    end else if (blocked_c && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sctag_cpx_outq.sv
// Bench for sctag_cpx_outq: directed vector table, async-reset-mid-pair
// sequence, then random traffic against a queue-based reference model.
module tb_sctag_cpx_outq;
  import sctag_cpx_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CREDITS = 2;

  logic                 rclk = 1'b0;
  logic                 arst;
  logic                 in_vld;
  logic [CPU_W-1:0]     in_cpu;
  logic                 in_atom;
  logic [CPX_PKT_W-1:0] in_data;
  logic                 in_stall;
  logic [NCPU-1:0]      req;
  logic                 atom;
  logic [CPX_PKT_W-1:0] data;
  logic [NCPU-1:0]      grant;
`ifdef SCTAG_CPX_STALL_CNT_EN
  logic [15:0]          stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 rclk = ~rclk;

  sctag_cpx_outq #(.DEPTH(DEPTH), .CREDITS(CREDITS)) dut (
    .rclk               (rclk),
    .arst               (arst),
    .in_vld             (in_vld),
    .in_cpu             (in_cpu),
    .in_atom            (in_atom),
    .in_data            (in_data),
    .in_stall           (in_stall),
    .sctag_cpx_req_cq   (req),
    .sctag_cpx_atom_cq  (atom),
    .sctag_cpx_data_ca  (data),
    .cpx_sctag_grant_cx (grant)
`ifdef SCTAG_CPX_STALL_CNT_EN
    ,
    .stall_cnt          (stall_cnt)
`endif
  );

  typedef struct packed {
    logic                 vld;
    logic [CPU_W-1:0]     cpu;
    logic                 atom;
    logic [CPX_PKT_W-1:0] data;
    logic [NCPU-1:0]      grant;
    logic [NCPU-1:0]      req;
    logic                 xatom;
    logic [CPX_PKT_W-1:0] xdata;
    logic                 stall;
  } vec_t;

  vec_t tv[$];

  function automatic logic [CPX_PKT_W-1:0] pk(input int c);
    pk = {16'(c), 113'd0, 16'(c)};
  endfunction

  task automatic chk(input string name, input logic [CPX_PKT_W-1:0] act, input logic [CPX_PKT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic drive(input logic v, input int c, input logic a, input logic [CPX_PKT_W-1:0] d, input int g);
    in_vld  = v;
    in_cpu  = CPU_W'(c);
    in_atom = a;
    in_data = d;
    grant   = NCPU'(g);
  endtask

  task automatic add(input bit v, input int c, input bit a, input int dc, input int g,
                     input int rq, input bit xa, input int xc, input bit st);
    vec_t r;
    r.vld = v; r.cpu = CPU_W'(c); r.atom = a; r.data = pk(dc); r.grant = NCPU'(g);
    r.req = NCPU'(rq); r.xatom = xa; r.xdata = pk(xc); r.stall = st;
    tv.push_back(r);
  endtask

  // Reference model state
  cpx_pkt_t             mq[$];
  int                   mcred[NCPU];
  bit                   m_second, m_stage_v, m_stall, exp_atom, pend;
  logic [NCPU-1:0]      exp_req;
  logic [CPX_PKT_W-1:0] exp_data, m_stage;
  int                   pend_cpu;

  task automatic model_edge();
    bit       full, issue, natom;
    cpx_pkt_t p;
    full  = (mq.size() == DEPTH);
    issue = 1'b0;
    natom = 1'b0;
    p     = '0;
    if (m_second) begin
      issue = 1'b1;
      m_second = 1'b0;
    end else if (mq.size() > 0) begin
      if (!mq[0].atom && mcred[mq[0].cpu] >= 1) begin
        issue = 1'b1;
      end else if (mq[0].atom && mq.size() >= 2 && mcred[mq[0].cpu] >= 2) begin
        issue = 1'b1;
        natom = 1'b1;
        m_second = 1'b1;
      end
    end
    exp_req = '0;
    if (issue) begin
      p = mq.pop_front();
      exp_req[p.cpu] = 1'b1;
      mcred[p.cpu] -= 1;
    end
    for (int i = 0; i < NCPU; i++) if (grant[i]) mcred[i] += 1;
    if (in_vld && !full) mq.push_back('{data: in_data, cpu: in_cpu, atom: in_atom});
    if (m_stage_v) exp_data = m_stage;
    m_stage_v = issue;
    m_stage   = p.data;
    exp_atom  = natom;
    m_stall   = (mq.size() >= DEPTH - 1);
  endtask

  initial begin
    arst = 1'b1;
    drive(0, 0, 0, '0, 0);

    // Directed table: credit use/return, held packets, atomic pair, stall/skid
    add(1,3,0,'h101,0,    'h00,0,'h000,0);
    add(0,0,0,0,0,        'h08,0,'h000,0);
    add(0,0,0,0,0,        'h00,0,'h101,0);
    add(1,3,0,'h102,0,    'h00,0,'h101,0);
    add(0,0,0,0,0,        'h08,0,'h101,0);
    add(1,3,0,'h103,0,    'h00,0,'h102,0);
    add(0,0,0,0,0,        'h00,0,'h102,0);
    add(0,0,0,0,'h08,     'h00,0,'h102,0);
    add(0,0,0,0,0,        'h08,0,'h102,0);
    add(0,0,0,0,0,        'h00,0,'h103,0);
    add(0,0,0,0,'h08,     'h00,0,'h103,0);
    add(0,0,0,0,'h08,     'h00,0,'h103,0);
    add(1,3,0,'h104,0,    'h00,0,'h103,0);
    add(0,0,0,0,'h08,     'h08,0,'h103,0);
    add(1,3,0,'h105,0,    'h00,0,'h104,0);
    add(1,3,0,'h106,0,    'h08,0,'h104,0);
    add(0,0,0,0,0,        'h08,0,'h105,0);
    add(0,0,0,0,0,        'h00,0,'h106,0);
    add(0,0,0,0,'h08,     'h00,0,'h106,0);
    add(0,0,0,0,'h08,     'h00,0,'h106,0);
    add(1,5,0,'h201,0,    'h00,0,'h106,0);
    add(1,5,0,'h202,0,    'h20,0,'h106,0);
    add(1,5,0,'h203,0,    'h20,0,'h201,0);
    add(0,0,0,0,0,        'h00,0,'h202,0);
    add(0,0,0,0,0,        'h00,0,'h202,0);
    add(0,0,0,0,'h20,     'h00,0,'h202,0);
    add(0,0,0,0,0,        'h20,0,'h202,0);
    add(0,0,0,0,0,        'h00,0,'h203,0);
    add(0,0,0,0,'h20,     'h00,0,'h203,0);
    add(0,0,0,0,'h20,     'h00,0,'h203,0);
    add(1,0,0,'h300,0,    'h00,0,'h203,0);
    add(0,0,0,0,0,        'h01,0,'h203,0);
    add(1,0,1,'h301,0,    'h00,0,'h300,0);
    add(1,0,0,'h302,0,    'h00,0,'h300,0);
    add(0,0,0,0,0,        'h00,0,'h300,0);
    add(0,0,0,0,'h01,     'h00,0,'h300,0);
    add(0,0,0,0,0,        'h01,1,'h300,0);
    add(0,0,0,0,0,        'h01,0,'h301,0);
    add(0,0,0,0,0,        'h00,0,'h302,0);
    add(0,0,0,0,'h01,     'h00,0,'h302,0);
    add(0,0,0,0,'h01,     'h00,0,'h302,0);
    add(1,6,0,'h401,0,    'h00,0,'h302,0);
    add(1,6,0,'h402,0,    'h40,0,'h302,0);
    add(0,0,0,0,0,        'h40,0,'h401,0);
    add(1,6,0,'h501,0,    'h00,0,'h402,0);
    add(1,6,0,'h502,0,    'h00,0,'h402,0);
    add(1,6,0,'h503,0,    'h00,0,'h402,1);
    add(1,6,0,'h504,0,    'h00,0,'h402,1);
    add(0,0,0,0,0,        'h00,0,'h402,1);
    add(0,0,0,0,'h40,     'h00,0,'h402,1);
    add(0,0,0,0,0,        'h40,0,'h402,1);
    add(0,0,0,0,'h40,     'h00,0,'h501,1);
    add(0,0,0,0,0,        'h40,0,'h501,0);
    add(0,0,0,0,'h40,     'h00,0,'h502,0);
    add(0,0,0,0,'h40,     'h40,0,'h502,0);
    add(0,0,0,0,0,        'h40,0,'h503,0);
    add(0,0,0,0,0,        'h00,0,'h504,0);
    add(0,0,0,0,'h40,     'h00,0,'h504,0);
    add(0,0,0,0,'h40,     'h00,0,'h504,0);

    repeat (2) @(posedge rclk);
    #1;
    chk("reset req", CPX_PKT_W'(req), '0);
    chk("reset atom", CPX_PKT_W'(atom), '0);
    chk("reset data", data, '0);
    chk("reset stall", CPX_PKT_W'(in_stall), '0);
    arst = 1'b0;

    foreach (tv[i]) begin
      drive(tv[i].vld, int'(tv[i].cpu), tv[i].atom, tv[i].data, int'(tv[i].grant));
      step();
      chk($sformatf("row%0d req", i), CPX_PKT_W'(req), CPX_PKT_W'(tv[i].req));
      chk($sformatf("row%0d atom", i), CPX_PKT_W'(atom), CPX_PKT_W'(tv[i].xatom));
      chk($sformatf("row%0d data", i), data, tv[i].xdata);
      chk($sformatf("row%0d stall", i), CPX_PKT_W'(in_stall), CPX_PKT_W'(tv[i].stall));
    end

    // Async reset while the first half of a pair is on the bus
    drive(1, 1, 1, pk('h601), 0); step();
    drive(1, 1, 0, pk('h602), 0); step();
    chk("pair wait req", CPX_PKT_W'(req), '0);
    drive(0, 0, 0, '0, 0); step();
    chk("atom1 req", CPX_PKT_W'(req), CPX_PKT_W'(8'h02));
    chk("atom1 atom", CPX_PKT_W'(atom), CPX_PKT_W'(1'b1));
    #2 arst = 1'b1;
    #1;
    chk("arst req", CPX_PKT_W'(req), '0);
    chk("arst atom", CPX_PKT_W'(atom), '0);
    chk("arst data", data, '0);
    chk("arst stall", CPX_PKT_W'(in_stall), '0);
    step();
    arst = 1'b0;
    step();
    chk("post arst empty", CPX_PKT_W'(req), '0);
    drive(1, 1, 0, pk('h701), 0); step();
    chk("post arst push1", CPX_PKT_W'(req), '0);
    drive(1, 1, 0, pk('h702), 0); step();
    chk("post arst req1", CPX_PKT_W'(req), CPX_PKT_W'(8'h02));
    drive(0, 0, 0, '0, 0); step();
    chk("post arst req2", CPX_PKT_W'(req), CPX_PKT_W'(8'h02));
    chk("post arst data1", data, pk('h701));
    step();
    chk("post arst data2", data, pk('h702));
    chk("post arst idle", CPX_PKT_W'(req), '0);

    // Random traffic against the reference model
    arst = 1'b1;
    step();
    arst = 1'b0;
    mq.delete();
    for (int i = 0; i < NCPU; i++) mcred[i] = CREDITS;
    m_second = 0; m_stage_v = 0; m_stall = 0; pend = 0; pend_cpu = 0;
    exp_data = '0; m_stage = '0;
    for (int n = 0; n < 1500; n++) begin
      logic v, a;
      int   c, g;
      v = !m_stall && ($urandom_range(0, 3) != 0);
      if (pend) begin
        c = pend_cpu;
        a = 1'b0;
      end else begin
        c = int'($urandom_range(0, NCPU - 1));
        a = ($urandom_range(0, 4) == 0);
      end
      if (v) begin
        pend     = a;
        pend_cpu = c;
      end
      g = 0;
      for (int i = 0; i < NCPU; i++)
        if (mcred[i] < CREDITS && $urandom_range(0, 2) == 0) g |= (1 << i);
      drive(v, c, a, {17'($urandom), $urandom, $urandom, $urandom, $urandom}, g);
      model_edge();
      step();
      chk($sformatf("rnd%0d req", n), CPX_PKT_W'(req), CPX_PKT_W'(exp_req));
      chk($sformatf("rnd%0d atom", n), CPX_PKT_W'(atom), CPX_PKT_W'(exp_atom));
      chk($sformatf("rnd%0d data", n), data, exp_data);
      chk($sformatf("rnd%0d stall", n), CPX_PKT_W'(in_stall), CPX_PKT_W'(m_stall));
    end
    drive(0, 0, 0, '0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
